// File: rtl/pic_inta_master.sv
// CPU-side interrupt-acknowledge sequencer: watches INTR, drives the two-pulse INTA
// handshake and hands the captured vector to the host through a one-deep valid/ready slot.
module pic_inta_master #(
    parameter int INTA_WIDTH = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        EN_I,
    input  logic        INTR_I,
    output logic        INTA_O,
    input  logic [7:0]  DataBus,
    output logic [7:0]  VEC_O,
    output logic        VEC_VALID_O,
    input  logic        VEC_READY_I,
    output logic        SPURIOUS_O,
    output logic        BUSY_O,
    output logic [15:0] ACK_CNT_O
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK1    = 3'd1,
        ST_GAP     = 3'd2,
        ST_ACK2    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic [15:0] W_LAST = 16'(INTA_WIDTH - 1);
    localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_r;
    logic [15:0] timer_r;
    logic        inta_r;
    logic [7:0]  vec_r;
    logic        vec_valid_r;
    logic        spurious_r;
    logic        busy_r;
    logic [15:0] ack_cnt_r;
    logic        slot_free_s;

    // Holding slot is free when empty or being drained on this edge.
    always_comb begin
        slot_free_s = 1'b0;
        if (!vec_valid_r || VEC_READY_I) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = 1'b0;
        end
    end

    // Sequencer FSM, holding register and capture counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r     <= ST_IDLE;
            timer_r     <= 16'd0;
            inta_r      <= 1'b0;
            vec_r       <= 8'h00;
            vec_valid_r <= 1'b0;
            spurious_r  <= 1'b0;
            busy_r      <= 1'b0;
            ack_cnt_r   <= 16'd0;
        end else begin
            spurious_r <= 1'b0;
            // Host handshake; a capture later in this block overrides the clear.
            if (vec_valid_r && VEC_READY_I) begin
                vec_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (EN_I && INTR_I && slot_free_s) begin
                        state_r <= ST_ACK1;
                        inta_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        timer_r <= 16'd0;
                    end
                end
                ST_ACK1: begin
                    if (timer_r == W_LAST) begin
                        state_r <= ST_GAP;
                        inta_r  <= 1'b0;
                        timer_r <= 16'd0;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (timer_r == G_LAST) begin
                        timer_r <= 16'd0;
                        if (INTR_I) begin
                            state_r <= ST_ACK2;
                            inta_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_RECOVER;
                            spurious_r <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_ACK2: begin
                    if (timer_r == W_LAST) begin
                        state_r     <= ST_RECOVER;
                        inta_r      <= 1'b0;
                        timer_r     <= 16'd0;
                        vec_r       <= DataBus;
                        vec_valid_r <= 1'b1;
                        if (ack_cnt_r != 16'hFFFF) begin
                            ack_cnt_r <= ack_cnt_r + 16'd1;
                        end
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                // Request is ignored here so pic has time to drop INTR.
                ST_RECOVER: begin
                    if (timer_r == G_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        timer_r <= 16'd0;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    inta_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    timer_r <= 16'd0;
                end
            endcase
        end
    end

    assign INTA_O      = inta_r;
    assign VEC_O       = vec_r;
    assign VEC_VALID_O = vec_valid_r;
    assign SPURIOUS_O  = spurious_r;
    assign BUSY_O      = busy_r;
    assign ACK_CNT_O   = ack_cnt_r;

endmodule

// File: tb/tb_pic_inta_master.sv
// Scoreboard bench for pic_inta_master: expected captures are queued by the stimulus and
// popped by a monitor whenever a new vector appears on the holding register.
module tb_pic_inta_master;

    logic        clk = 1'b0;
    logic        rst, en, intr, rdy;
    logic [7:0]  db;
    logic        inta, vvalid, spur, busy;
    logic [7:0]  vec;
    logic [15:0] cnt;

    logic        rst2, en2, intr2, rdy2;
    logic [7:0]  db2;
    logic        inta2, vvalid2, spur2, busy2;
    logic [7:0]  vec2;
    logic [15:0] cnt2;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    pic_inta_master u_dut (
        .CLK_I(clk), .RST_I(rst), .EN_I(en), .INTR_I(intr), .INTA_O(inta),
        .DataBus(db), .VEC_O(vec), .VEC_VALID_O(vvalid), .VEC_READY_I(rdy),
        .SPURIOUS_O(spur), .BUSY_O(busy), .ACK_CNT_O(cnt)
    );

    pic_inta_master #(.INTA_WIDTH(3), .GAP_CYCLES(2)) u_dut3 (
        .CLK_I(clk), .RST_I(rst2), .EN_I(en2), .INTR_I(intr2), .INTA_O(inta2),
        .DataBus(db2), .VEC_O(vec2), .VEC_VALID_O(vvalid2), .VEC_READY_I(rdy2),
        .SPURIOUS_O(spur2), .BUSY_O(busy2), .ACK_CNT_O(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a newly presented vector must match the head of the queue.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_vec;
        logic [23:0] e;
        prev_valid = 1'b0;
        prev_vec   = 8'h00;
        forever begin
            @(negedge clk);
            if (vvalid === 1'b1 && (!prev_valid || vec !== prev_vec)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual vec=%0h cnt=%0h required none", vec, cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_vec", {24'd0, vec}, {24'd0, e[23:16]});
                    chk("sb_cnt", {16'd0, cnt}, {16'd0, e[15:0]});
                end
            end
            prev_valid = vvalid;
            prev_vec   = vec;
        end
    end

    // Start at the current negedge; check INTA 1,1,0,1,1 then the capture edge.
    task automatic run_seq(input logic [7:0] v, input logic rdy0, input logic rdy_rest,
                           input logic en_rest, input logic drop);
        logic [4:0] pat;
        pat  = 5'b11011;
        en   = 1'b1;
        intr = 1'b1;
        db   = v;
        rdy  = rdy0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rdy = rdy_rest;
                en  = en_rest;
            end
            chk("inta_seq", {31'd0, inta}, {31'd0, pat[i]});
            chk("busy_seq", {31'd0, busy}, 32'd1);
            if (i == 4) begin
                chk("valid_pre", {31'd0, vvalid}, 32'd0);
                if (drop) intr = 1'b0;
            end
        end
        @(negedge clk);
        chk("valid_cap", {31'd0, vvalid}, 32'd1);
        chk("inta_cap", {31'd0, inta}, 32'd0);
    endtask

    initial begin
        logic [7:0] p2;
        logic [5:0] spur_pat;
        logic [5:0] inta_sp;
        rst = 1'b1; en = 1'b0; intr = 1'b0; rdy = 1'b0; db = 8'h00;
        rst2 = 1'b1; en2 = 1'b0; intr2 = 1'b0; rdy2 = 1'b0; db2 = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_inta", {31'd0, inta}, 32'd0);
        chk("rst_vec", {24'd0, vec}, 32'd0);
        chk("rst_valid", {31'd0, vvalid}, 32'd0);
        chk("rst_spur", {31'd0, spur}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        rst = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);

        // Basic capture, slot left full.
        exp_q.push_back({8'h5A, 16'd1});
        run_seq(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cnt_first", {16'd0, cnt}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("inta_full", {31'd0, inta}, 32'd0);
        end
        chk("vec_held", {24'd0, vec}, 32'h5A);

        // Overlap: consume 0x5A and start on the same edge.
        exp_q.push_back({8'hA3, 16'd2});
        run_seq(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("vec_ovl", {24'd0, vec}, 32'hA3);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("valid_drain", {31'd0, vvalid}, 32'd0);
        @(negedge clk);

        // Spurious: INTR high for two cycles only.
        spur_pat = 6'b001000;
        inta_sp  = 6'b000011;
        en = 1'b1; intr = 1'b1; db = 8'hEE;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) intr = 1'b0;
            chk("spur_inta", {31'd0, inta}, {31'd0, inta_sp[i]});
            chk("spur_pulse", {31'd0, spur}, {31'd0, spur_pat[i]});
            chk("spur_valid", {31'd0, vvalid}, 32'd0);
        end
        chk("spur_cnt", {16'd0, cnt}, 32'd2);
        @(negedge clk);

        // Reset during the second ACK2 cycle.
        en = 1'b1; intr = 1'b1; db = 8'h77;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("pre_rst_inta", {31'd0, inta}, 32'd1);
        rst = 1'b1; intr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_inta", {31'd0, inta}, 32'd0);
        chk("mrst_valid", {31'd0, vvalid}, 32'd0);
        chk("mrst_cnt", {16'd0, cnt}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Enable gating and dropping EN inside ACK1.
        en = 1'b0; intr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_off_inta", {31'd0, inta}, 32'd0);
        end
        exp_q.push_back({8'hC3, 16'd1});
        run_seq(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);

        // Saturation.
        force u_dut.ack_cnt_r = 16'hFFFE;
        @(negedge clk);
        release u_dut.ack_cnt_r;
        exp_q.push_back({8'h11, 16'hFFFF});
        run_seq(8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        exp_q.push_back({8'h22, 16'hFFFF});
        run_seq(8'h22, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("sat_cnt", {16'd0, cnt}, 32'hFFFF);
        rdy = 1'b0;
        repeat (2) @(negedge clk);

        // W=3, G=2 instance.
        p2 = 8'b11100111;
        en2 = 1'b1; intr2 = 1'b1; db2 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w3_inta", {31'd0, inta2}, {31'd0, p2[7-i]});
            chk("w3_valid_pre", {31'd0, vvalid2}, 32'd0);
            if (i == 7) intr2 = 1'b0;
        end
        @(negedge clk);
        chk("w3_valid", {31'd0, vvalid2}, 32'd1);
        chk("w3_vec", {24'd0, vec2}, 32'h3C);
        chk("w3_cnt", {16'd0, cnt2}, 32'd1);
        chk("w3_inta_end", {31'd0, inta2}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
